mult_accumulator: RTL and testbench

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

---
 rtl/mult_acc_pkg.sv | 14 +
 rtl/sat_adder.sv | 25 ++
 rtl/mult_accumulator.sv | 116 +++++++++++
 tb/tb_mult_accumulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - shared state encoding and width defaults for mult_accumulator
package mult_acc_pkg;

  localparam int ACC_W_DEF = 36;
  localparam int CNT_W_DEF = 8;
  localparam int PROD_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - unsigned adder with carry-out detect and optional saturation
module sat_adder #(
  parameter int W = 36
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sat_en,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  // one extra bit catches the carry; saturate clamps to all-ones, wrap keeps the low W bits
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    ovf = raw[W];
    if (raw[W] && sat_en) begin
      sum = {W{1'b1}};
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - sums a counted stream of 32-bit products with wrap or saturate
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              sat_en,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  acc_state_t       state;
  acc_state_t       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] len_q;
  logic             sat_q;
  logic             ovf_q;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             xfer;

  assign xfer      = (state == ACCUM) && prod_valid;
  assign count_nxt = count + CNT_W'(1);
  assign add_b     = ACC_W'(prod);

  sat_adder #(
    .W (ACC_W)
  ) u_sat_adder (
    .a      (acc),
    .b      (add_b),
    .sat_en (sat_q),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: start only counts in IDLE, so a start during the DONE handshake is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (count_nxt == len_q)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: clear and latch run config on start, accumulate on each accepted product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        acc   <= '0;
        count <= '0;
        len_q <= len;
        sat_q <= sat_en;
        ovf_q <= 1'b0;
      end else if (xfer) begin
        acc   <= add_sum;
        count <= count_nxt;
        if (add_ovf) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // outputs decode straight from state so reset clears them without waiting for a clock
  always_comb begin
    prod_ready = (state == ACCUM);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
    acc_out    = acc;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - directed self-checking bench for mult_accumulator
module tb_mult_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        sat_en;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [35:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mult_accumulator #(
    .ACC_W (36),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .sat_en     (sat_en),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [7:0] n, input logic s);
    start  = 1'b1;
    len    = n;
    sat_en = s;
    tick();
    start  = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] p);
    prod_valid = 1'b1;
    prod       = p;
    repeat (n) tick();
    prod_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = 8'd0;
    sat_en     = 1'b0;
    prod       = 32'd0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    #2;
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_prod_ready",64'(prod_ready), 64'd0);
    check("rst_acc_out",   64'(acc_out),    64'd0);
    check("rst_overflow",  64'(overflow),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic run: 6+7+8
    begin_run(8'd3, 1'b0);
    check("basic_prod_ready", 64'(prod_ready), 64'd1);
    check("basic_busy",       64'(busy),       64'd1);
    prod_valid = 1'b1;
    prod = 32'd6; tick();
    prod = 32'd7; tick();
    check("basic_not_done_yet", 64'(out_valid), 64'd0);
    prod = 32'd8; tick();
    prod_valid = 1'b0;
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_acc",       64'(acc_out),   64'h15);
    check("basic_ovf",       64'(overflow),  64'd0);
    check("basic_prod_ready_done", 64'(prod_ready), 64'd0);
    handshake();
    check("basic_idle_busy",  64'(busy),      64'd0);
    check("basic_idle_valid", 64'(out_valid), 64'd0);
    check("basic_idle_hold",  64'(acc_out),   64'h15);

    // gaps and backpressure
    begin_run(8'd2, 1'b0);
    repeat (3) tick();
    check("gap_acc_zero", 64'(acc_out),    64'd0);
    check("gap_ready",    64'(prod_ready), 64'd1);
    feed(1, 32'd100);
    repeat (3) tick();
    check("gap_partial", 64'(acc_out), 64'd100);
    check("gap_not_done", 64'(out_valid), 64'd0);
    feed(1, 32'd200);
    prod_valid = 1'b1;
    prod       = 32'd55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_acc",   64'(acc_out),   64'h12C);
      check("stall_busy",  64'(busy),      64'd1);
    end
    prod_valid = 1'b0;
    start      = 1'b1;
    len        = 8'd4;
    handshake();
    check("hs_start_ignored_busy", 64'(busy),    64'd0);
    check("hs_acc_hold",           64'(acc_out), 64'h12C);
    start = 1'b0;
    tick();
    check("hs_still_idle", 64'(busy), 64'd0);

    // saturate
    begin_run(8'd17, 1'b1);
    feed(17, 32'hFFFE0001);
    check("sat_valid", 64'(out_valid), 64'd1);
    check("sat_acc",   64'(acc_out),   64'hFFFFFFFFF);
    check("sat_ovf",   64'(overflow),  64'd1);
    handshake();
    check("sat_idle_ovf_hold", 64'(overflow), 64'd1);

    // wrap, then a non-overflowing run clears the flag
    begin_run(8'd17, 1'b0);
    check("wrap_ovf_cleared_on_start", 64'(overflow), 64'd0);
    feed(17, 32'hFFFE0001);
    check("wrap_acc", 64'(acc_out),  64'h0FFDE0011);
    check("wrap_ovf", 64'(overflow), 64'd1);
    handshake();
    begin_run(8'd16, 1'b0);
    feed(16, 32'hFFFE0001);
    check("len16_acc", 64'(acc_out),  64'hFFFE00010);
    check("len16_ovf", 64'(overflow), 64'd0);
    handshake();

    // len = 0 goes straight to DONE
    begin_run(8'd0, 1'b0);
    check("len0_valid", 64'(out_valid), 64'd1);
    check("len0_acc",   64'(acc_out),   64'd0);
    check("len0_ready", 64'(prod_ready),64'd0);
    handshake();

    // start while accumulating is ignored
    begin_run(8'd2, 1'b0);
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    check("accum_start_busy",  64'(busy),       64'd1);
    check("accum_start_ready", 64'(prod_ready), 64'd1);
    check("accum_start_valid", 64'(out_valid),  64'd0);
    prod_valid = 1'b1;
    prod = 32'd3; tick();
    prod = 32'd4; tick();
    prod_valid = 1'b0;
    check("accum_start_acc",   64'(acc_out),   64'd7);
    check("accum_start_done",  64'(out_valid), 64'd1);
    handshake();

    // reset mid-run
    begin_run(8'd5, 1'b0);
    feed(2, 32'd5);
    check("mid_partial", 64'(acc_out), 64'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_ready", 64'(prod_ready), 64'd0);
    check("mid_rst_valid", 64'(out_valid),  64'd0);
    check("mid_rst_acc",   64'(acc_out),    64'd0);
    check("mid_rst_ovf",   64'(overflow),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_busy",  64'(busy),      64'd0);
    begin_run(8'd1, 1'b0);
    feed(1, 32'd9);
    check("fresh_valid", 64'(out_valid), 64'd1);
    check("fresh_acc",   64'(acc_out),   64'd9);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
